// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM states and cause encodings.
package zktc_trap_pkg;

  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRAP,
    ST_RFI,
    ST_SETTLE
  } trap_state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 4'h0;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL    = 4'h1;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ_BASE = 4'h8;

  function automatic logic [CAUSE_W-1:0] irq_cause(input logic [2:0] idx);
    return CAUSE_IRQ_BASE | {1'b0, idx};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline <-> trap controller signal bundle; master is the pipeline side.
interface trap_ctrl_if
  import zktc_trap_pkg::*;
#(
  parameter int unsigned NIRQ = 4
);
  logic               retire;
  logic               ecall;
  logic               illegal;
  logic               rfi_req;
  logic [NIRQ-1:0]    irq;
  logic [15:0]        psr;
  logic               trap;
  logic               rfi;
  logic [CAUSE_W-1:0] cause;
  logic               flush;
  logic [NIRQ-1:0]    pending;

  modport master (
    output retire, ecall, illegal, rfi_req, irq, psr,
    input  trap, rfi, cause, flush, pending
  );

  modport slave (
    input  retire, ecall, illegal, rfi_req, irq, psr,
    output trap, rfi, cause, flush, pending
  );
endinterface

// File: rtl/trap_ctrl_irq_edge.sv
// Per-line rising-edge detector with a sticky pending flag; a new edge beats a clear.
module trap_irq_edge (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic irq,
  input  logic clr,
  output logic pending
);
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= irq;
      if (arm && irq && !prev)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end
endmodule

// File: rtl/trap_ctrl.sv
// Trap/return-from-trap sequencer: picks exceptions and interrupts at instruction
// boundaries and pulses the control-register file.
module trap_ctrl
  import zktc_trap_pkg::*;
#(
  parameter int unsigned NIRQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  bus
);
  trap_state_e        state, state_nx;
  logic [CAUSE_W-1:0] cause_q, cause_nx;
  logic [NIRQ-1:0]    pend, take;
  logic               armed;
  logic               irq_hit;
  logic [2:0]         irq_idx;
  logic               unused_psr;

  assign unused_psr = ^{bus.psr[15:2], bus.psr[0]};

  // Edge samples are zero out of reset; the first cycle after release only
  // loads them, so a line held high through reset does not look like an edge.
  always_ff @(posedge clk) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  for (genvar g = 0; g < NIRQ; g++) begin : g_line
    trap_irq_edge u_edge (
      .clk     (clk),
      .rst     (rst),
      .arm     (armed),
      .irq     (bus.irq[g]),
      .clr     (take[g]),
      .pending (pend[g])
    );
  end

  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int unsigned i = NIRQ; i > 0; i--) begin
      if (pend[i-1]) begin
        irq_hit = 1'b1;
        irq_idx = 3'(i - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cause_q <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    take     = '0;
    unique case (state)
      ST_RUN: begin
        if (bus.retire) begin
          if (bus.illegal) begin
            state_nx = ST_TRAP;
            cause_nx = CAUSE_ILLEGAL;
          end else if (bus.ecall) begin
            state_nx = ST_TRAP;
            cause_nx = CAUSE_ECALL;
          end else if (bus.rfi_req) begin
            state_nx = ST_RFI;
          end else if (irq_hit && !bus.psr[1]) begin
            state_nx = ST_TRAP;
            cause_nx = irq_cause(irq_idx);
            take     = NIRQ'(1) << irq_idx;
          end
        end
      end
      ST_TRAP:   state_nx = ST_SETTLE;
      ST_RFI:    state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_RUN;
      default:   state_nx = ST_RUN;
    endcase
  end

  assign bus.trap    = (state == ST_TRAP);
  assign bus.rfi     = (state == ST_RFI);
  assign bus.flush   = (state != ST_RUN);
  assign bus.cause   = cause_q;
  assign bus.pending = pend;
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter NIRQ, default 4, number of external interrupt lines (1..8).
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 retire  in  1  an instruction completes this cycle (instruction boundary).
REQ-005 ecall  in  1  retiring instruction is a software trap; qualified by retire.
REQ-006 illegal  in  1  retiring instruction is undecodable; qualified by retire.
REQ-007 rfi_req  in  1  retiring instruction is return-from-trap; qualified by retire.
REQ-008 irq  in  NIRQ  external interrupt lines, level, synchronous to clk.
REQ-009 psr  in  16  current PSR; bit1 = interrupts masked, bit0 = supervisor.
REQ-010 trap  out  1  one-cycle pulse to control-register file: load PC_TRAP, save PC/PSR.
REQ-011 rfi  out  1  one-cycle pulse to control-register file: restore PC/PSR.
REQ-012 cause  out  4  cause of most recent trap.
REQ-013 flush  out  1  pipeline must discard in-flight instructions.
REQ-014 pending  out  NIRQ  latched, not-yet-taken interrupt edges.

Function
REQ-015 SHALL implement FSM states RUN, TRAP, RFI, SETTLE.
REQ-016 SHALL latch pending[n] on every 0->1 edge of irq[n] (previous-cycle sample held per line), in any state.
REQ-017 Cause encoding SHALL be: illegal 4'h0, ecall 4'h1, interrupt n 4'h8+n.
REQ-018 In RUN with retire=1, SHALL select by priority illegal > ecall > rfi_req > lowest-index pending interrupt with psr[1]=0.
REQ-019 Selected illegal/ecall/interrupt SHALL move FSM to TRAP and register cause; trap=1 and flush=1 the next cycle (latency 1).
REQ-020 Selected rfi_req SHALL move FSM to RFI; rfi=1 and flush=1 the next cycle.
REQ-021 Synchronous exceptions SHALL be taken regardless of psr[1]; interrupts SHALL NOT be taken while psr[1]=1 (remain pending).
REQ-022 TRAP and RFI SHALL each last exactly one cycle and go to SETTLE; SETTLE lasts one cycle with flush=1, then RUN.
REQ-023 retire, ecall, illegal, rfi_req SHALL be ignored outside RUN.
REQ-024 Taking interrupt n SHALL clear pending[n] in the TRAP-entry cycle; a new edge on line n in that same cycle SHALL leave pending[n] set.
REQ-025 cause SHALL hold its value until the next trap; unchanged by rfi.
REQ-026 ecall and rfi_req simultaneously SHALL take ecall; rfi dropped.
REQ-027 trap and rfi SHALL never be high in the same cycle.

Reset
REQ-028 On rst: state RUN, trap=0, rfi=0, flush=0, cause=4'h0, pending all 0, edge samples 0.
REQ-029 rst mid-TRAP/RFI/SETTLE SHALL abort the sequence with no further pulse; rst takes precedence over all inputs.
REQ-030 irq held high through reset release SHALL NOT create a pending edge.

Structure
REQ-031 Package zktc_trap_pkg SHALL hold the FSM state enum, cause constants, cause width.
REQ-032 Sub-module trap_irq_edge (one per line: edge detect + pending flop with set/clear) SHALL be instantiated NIRQ times.

Verification
REQ-033 Reset, then retire=1 illegal=1 -> next cycle trap=1 flush=1 cause=4'h0; flush=1 one more cycle; then RUN.
REQ-034 psr=16'h0000, pulse irq[2] and irq[1], retire=1 -> trap with cause=4'h9, pending=4'b0100; after SETTLE + retire -> cause=4'hA, pending=0.
REQ-035 psr=16'h0002, pulse irq[0], retire=1 for 10 cycles -> no trap, pending=4'b0001; psr=0 + retire -> trap, cause=4'h8.
REQ-036 retire=1 ecall=1 rfi_req=1 -> trap=1 cause=4'h1, rfi stays 0; retire=1 rfi_req=1 in RUN -> rfi=1 for one cycle, cause unchanged.
REQ-037 illegal accepted, rst asserted during TRAP -> trap=0 next cycle, flush=0, cause=4'h0, pending=0.
REQ-038 irq[3] edge in SETTLE with retire=1 ecall=1 -> ecall ignored; pending[3]=1; taken at next RUN retire.
